// File: rtl/eeprom_xfer_ctrl_if.sv
// Bundle of the user command/data stream and the I2C byte-master bus
// for eeprom_xfer_ctrl.
// The "master" modport is the controller view (it masters the I2C byte
// engine); the "slave" modport is the surrounding system / I2C engine view.
interface eeprom_xfer_ctrl_if #(
   parameter int ADR_W = 10,
   parameter int LEN_W = 11
) ();
   // Handshakes: cmd_valid/cmd_ready transfer a command on a rising clock
   // edge where both are high; cmd_valid is only honoured while the
   // controller is idle. wr_req and rd_valid are single-cycle strobes with
   // no back-pressure.
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_rw;
   logic [ADR_W-1:0] cmd_adr;
   logic [LEN_W-1:0] cmd_len;
   logic [7:0]       wr_data;
   logic             wr_req;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             done;
   logic             error;
   // I2C byte-master side
   logic             m_enable;
   logic             m_rw;
   logic             m_ur;
   logic [6:0]       m_devadr;
   logic [7:0]       m_regadr;
   logic [15:0]      m_datnum;
   logic [7:0]       m_dat;
   logic             m_busy;
   logic             m_dvalid;
   logic             m_newdat;
   logic [7:0]       m_dat_i;

   modport master (
      input  cmd_valid, cmd_rw, cmd_adr, cmd_len, wr_data,
      input  m_busy, m_dvalid, m_newdat, m_dat_i,
      output cmd_ready, wr_req, rd_data, rd_valid, done, error,
      output m_enable, m_rw, m_ur, m_devadr, m_regadr, m_datnum, m_dat
   );

   modport slave (
      output cmd_valid, cmd_rw, cmd_adr, cmd_len, wr_data,
      output m_busy, m_dvalid, m_newdat, m_dat_i,
      input  cmd_ready, wr_req, rd_data, rd_valid, done, error,
      input  m_enable, m_rw, m_ur, m_devadr, m_regadr, m_datnum, m_dat
   );
endinterface

// File: rtl/eeprom_xfer_ctrl.sv
// eeprom_xfer_ctrl: splits a byte-addressed EEPROM transfer into I2C
// segments that never cross a write page or the top of the address space,
// and sequences an I2C byte-master engine through them.
// Optional feature macro: EEPROM_WRWAIT_EN adds a TWR_CYCLES wait after
// every write segment (EEPROM internal write cycle).
module eeprom_xfer_ctrl #(
   parameter int ADR_W      = 10,
   parameter int PAGE       = 16,
   parameter int LEN_W      = 11,
   parameter int TWR_CYCLES = 2000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   eeprom_xfer_ctrl_if.master   bus,
   output logic [2:0]           dbg_state
);

   // Elaboration-time parameter sanity
   if (ADR_W < 8 || ADR_W > 11) begin : g_bad_adr_w
      $error("eeprom_xfer_ctrl: ADR_W must be in 8..11");
   end
   if (PAGE < 8 || PAGE > 256 || (PAGE & (PAGE - 1)) != 0) begin : g_bad_page
      $error("eeprom_xfer_ctrl: PAGE must be a power of two in 8..256");
   end
   if (TWR_CYCLES < 1) begin : g_bad_twr
      $error("eeprom_xfer_ctrl: TWR_CYCLES must be at least 1");
   end

   // Encodings are fixed so dbg_state means the same in both builds.
`ifdef EEPROM_WRWAIT_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0, SETUP = 3'd1, START = 3'd2, RUN = 3'd3,
      WAITSTOP = 3'd4, TWR = 3'd5, DONE = 3'd6
   } state_t;
   localparam int TWR_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
   logic [TWR_W-1:0] twr_cnt;
   logic             twr_run;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, SETUP = 3'd1, START = 3'd2, RUN = 3'd3,
      WAITSTOP = 3'd4, DONE = 3'd6
   } state_t;
`endif

   state_t state, state_nxt;

   logic             rw;
   logic [ADR_W-1:0] adr;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] seg;
   logic [LEN_W-1:0] seg_cnt;
   logic [3:0]       tmo;
   logic             error_q;
   logic             rd_valid_q;
   logic [7:0]       rd_data_q;

   // Control strobes from the FSM to the datapath
   logic             accept;
   logic             load_seg;
   logic             tmo_run;
   logic             count_en;
   logic             set_err;
   logic             strobe;

   logic [31:0]      page_left;
   logic [31:0]      wrap_left;
   logic [31:0]      cap;
   logic [LEN_W-1:0] seg_calc;

   // Segment length: remaining bytes, cut at the page end for writes and
   // at the top of the address space for every transfer.
   always_comb begin
      page_left = 32'(PAGE) - (32'(adr) & 32'(PAGE - 1));
      wrap_left = (32'd1 << ADR_W) - 32'(adr);
      cap       = 32'(rem);
      if (!rw && page_left < cap) cap = page_left;
      if (wrap_left < cap) cap = wrap_left;
      seg_calc  = LEN_W'(cap);
   end

   // The byte strobe that counts depends on the transfer direction.
   assign strobe = rw ? bus.m_dvalid : bus.m_newdat;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      load_seg      = 1'b0;
      tmo_run       = 1'b0;
      count_en      = 1'b0;
      set_err       = 1'b0;
`ifdef EEPROM_WRWAIT_EN
      twr_run       = 1'b0;
`endif
      bus.cmd_ready = 1'b0;
      bus.m_enable  = 1'b0;
      bus.done      = 1'b0;
      bus.wr_req    = 1'b0;
      case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            // Only a zero-length command arrives here with nothing left.
            if (rem == '0) state_nxt = DONE;
            else begin
               load_seg  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            bus.m_enable = 1'b1;
            if (bus.m_busy) state_nxt = RUN;
            else if (tmo == 4'd7) begin
               set_err   = 1'b1;
               state_nxt = DONE;
            end else tmo_run = 1'b1;
         end
         RUN: begin
            count_en   = 1'b1;
            bus.wr_req = !rw && bus.m_newdat;
            if (!bus.m_busy) state_nxt = WAITSTOP;
         end
         WAITSTOP: begin
            if (seg_cnt != seg) begin
               set_err   = 1'b1;
               state_nxt = DONE;
            end
`ifdef EEPROM_WRWAIT_EN
            else if (!rw) state_nxt = TWR;
`endif
            else if (rem == '0) state_nxt = DONE;
            else state_nxt = SETUP;
         end
`ifdef EEPROM_WRWAIT_EN
         TWR: begin
            if (twr_cnt == TWR_W'(TWR_CYCLES - 1))
               state_nxt = (rem == '0) ? DONE : SETUP;
            else twr_run = 1'b1;
         end
`endif
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transfer datapath: command latch, address/remaining bookkeeping,
   // segment strobe count, start timeout, sticky error and read capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rw         <= 1'b0;
         adr        <= '0;
         rem        <= '0;
         seg        <= '0;
         seg_cnt    <= '0;
         tmo        <= '0;
         error_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         if (accept) begin
            rw      <= bus.cmd_rw;
            adr     <= bus.cmd_adr;
            rem     <= bus.cmd_len;
            error_q <= 1'b0;
         end
         if (load_seg) begin
            seg     <= seg_calc;
            seg_cnt <= '0;
         end
         if (count_en && strobe) begin
            adr     <= adr + 1'b1;
            if (rem != '0) rem <= rem - 1'b1;
            seg_cnt <= seg_cnt + 1'b1;
         end
         if (set_err) error_q <= 1'b1;
         tmo        <= tmo_run ? tmo + 4'd1 : 4'd0;
         rd_valid_q <= count_en && rw && bus.m_dvalid;
         if (count_en && rw && bus.m_dvalid) rd_data_q <= bus.m_dat_i;
      end
   end

`ifdef EEPROM_WRWAIT_EN
   // Write-cycle wait counter, cleared whenever the wait is not running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     twr_cnt <= '0;
      else if (twr_run) twr_cnt <= twr_cnt + 1'b1;
      else              twr_cnt <= '0;
   end
`endif

   // Bus outputs derived from the registered transfer state
   assign bus.m_devadr = 7'h50 | 7'(adr >> 8);
   assign bus.m_regadr = adr[7:0];
   assign bus.m_datnum = 16'(seg);
   assign bus.m_rw     = rw;
   assign bus.m_ur     = 1'b0;
   assign bus.m_dat    = bus.wr_data;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.error    = error_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_eeprom_xfer_ctrl.sv
// Bench for eeprom_xfer_ctrl: table of directed transfers with hand-worked
// segment lists, plus hand sequences for start timeout, zero length and
// reset during a transfer. A behavioural I2C byte engine answers m_enable.
module tb_eeprom_xfer_ctrl;
   localparam int ADR_W = 10;
   localparam int LEN_W = 11;
   localparam int NV    = 7;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] dbg_state;

   eeprom_xfer_ctrl_if #(.ADR_W(ADR_W), .LEN_W(LEN_W)) bus ();

   eeprom_xfer_ctrl #(.ADR_W(ADR_W), .PAGE(16), .LEN_W(LEN_W), .TWR_CYCLES(2000)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            rw;
      logic [9:0]      adr;
      logic [10:0]     len;
      int              nseg;
      logic [2:0][9:0] sa;   // start address of each segment
      logic [2:0][15:0] sl;  // length of each segment
   } vec_t;

   vec_t        vec [NV];
   int          n_vec = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   logic [31:0] seg_q [$];
   logic [7:0]  exp_q [$];
   logic [7:0]  rd_pat = 8'h11;
   bit          resp_en = 1'b1;
   logic        en_q = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rw, input logic [9:0] adr, input logic [10:0] len,
                               input int nseg, input logic [9:0] a0, input logic [15:0] l0,
                               input logic [9:0] a1, input logic [15:0] l1,
                               input logic [9:0] a2, input logic [15:0] l2);
      vec_t v;
      v.rw = rw; v.adr = adr; v.len = len; v.nseg = nseg;
      v.sa[0] = a0; v.sa[1] = a1; v.sa[2] = a2;
      v.sl[0] = l0; v.sl[1] = l1; v.sl[2] = l2;
      return v;
   endfunction

   // Behavioural I2C byte engine: raises busy on m_enable, issues m_datnum
   // byte strobes spaced one cycle apart, then drops busy.
   initial begin
      int         n;
      logic       r;
      logic [7:0] b;
      bus.m_busy = 1'b0; bus.m_dvalid = 1'b0; bus.m_newdat = 1'b0; bus.m_dat_i = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (resp_en && bus.m_enable) begin
            n = int'(bus.m_datnum);
            r = bus.m_rw;
            bus.m_busy = 1'b1;
            for (int i = 0; i < n; i++) begin
               @(posedge clk); #1;
               if (r) begin
                  b = rd_pat;
                  rd_pat = rd_pat + 8'd37;
                  bus.m_dat_i = b;
                  exp_q.push_back(b);
                  bus.m_dvalid = 1'b1;
               end else bus.m_newdat = 1'b1;
               @(posedge clk); #1;
               bus.m_dvalid = 1'b0;
               bus.m_newdat = 1'b0;
            end
            @(posedge clk); #1;
            bus.m_busy = 1'b0;
         end
      end
   end

   // Monitor: pulse counters, segment log, read-data scoreboard
   always @(negedge clk) begin
      if (bus.done) done_cnt++;
      if (bus.wr_req) wr_cnt++;
      if (bus.rd_valid) begin
         rd_cnt++;
         if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL rd_data: got 0x%0h with no byte outstanding", bus.rd_data);
         end else check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
      if (bus.m_enable && !en_q) begin
         seg_q.push_back({bus.m_rw, bus.m_devadr, bus.m_regadr, bus.m_datnum});
         check("m_ur", 32'(bus.m_ur), 32'd0);
      end
      en_q = bus.m_enable;
   end

   task automatic send_cmd(input logic rw, input logic [9:0] adr, input logic [10:0] len);
      int k = 0;
      while (!bus.cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
      check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_rw = rw; bus.cmd_adr = adr; bus.cmd_len = len;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (done_cnt == 0 && k < limit) begin @(negedge clk); k++; end
      check("done_seen", 32'(done_cnt > 0), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          k, en_cnt, done_at, wr_at_rst;
      logic        err_at_done;
      logic [31:0] s, e;

      vec[0] = mk(1'b0, 10'h00E, 11'd20, 3, 10'h00E, 16'd2, 10'h010, 16'd16, 10'h020, 16'd2);
      vec[1] = mk(1'b1, 10'h3FE, 11'd4,  2, 10'h3FE, 16'd2, 10'h000, 16'd2,  10'h000, 16'd0);
      vec[2] = mk(1'b0, 10'h000, 11'd16, 1, 10'h000, 16'd16, 10'h000, 16'd0, 10'h000, 16'd0);
      vec[3] = mk(1'b1, 10'h123, 11'd5,  1, 10'h123, 16'd5, 10'h000, 16'd0,  10'h000, 16'd0);
      vec[4] = mk(1'b0, 10'h3FD, 11'd5,  2, 10'h3FD, 16'd3, 10'h000, 16'd2,  10'h000, 16'd0);
      vec[5] = mk(1'b1, 10'h0FF, 11'd3,  1, 10'h0FF, 16'd3, 10'h000, 16'd0,  10'h000, 16'd0);
      vec[6] = mk(1'b0, 10'h105, 11'd1,  1, 10'h105, 16'd1, 10'h000, 16'd0,  10'h000, 16'd0);

      bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_adr = '0; bus.cmd_len = '0;
      bus.wr_data = 8'hA5;

      // Reset values
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst m_enable",  32'(bus.m_enable),  32'd0);
      check("rst done",      32'(bus.done),      32'd0);
      check("rst error",     32'(bus.error),     32'd0);
      check("rst rd_valid",  32'(bus.rd_valid),  32'd0);
      check("rst wr_req",    32'(bus.wr_req),    32'd0);
      check("rst rd_data",   32'(bus.rd_data),   32'd0);
      check("rst state",     32'(dbg_state),     32'd0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Write data passes straight through to the engine
      bus.wr_data = 8'h3C; #1;
      check("m_dat passthru", 32'(bus.m_dat), 32'h3C);

      // Directed transfer table
      for (int i = 0; i < NV; i++) begin
         done_cnt = 0; wr_cnt = 0; rd_cnt = 0; seg_q.delete();
         send_cmd(vec[i].rw, vec[i].adr, vec[i].len);
         wait_done(20000);
         check($sformatf("v%0d nseg", i), 32'(seg_q.size()), 32'(vec[i].nseg));
         for (int j = 0; j < vec[i].nseg; j++) begin
            if (j < seg_q.size()) begin
               s = seg_q[j];
               e = {vec[i].rw, 7'h50 | {5'd0, vec[i].sa[j][9:8]}, vec[i].sa[j][7:0], vec[i].sl[j]};
               check($sformatf("v%0d seg%0d {rw,dev,reg,num}", i, j), s, e);
            end
         end
         check($sformatf("v%0d strobes", i), 32'(vec[i].rw ? rd_cnt : wr_cnt), 32'(vec[i].len));
         check($sformatf("v%0d other strobes", i), 32'(vec[i].rw ? wr_cnt : rd_cnt), 32'd0);
         check($sformatf("v%0d done pulses", i), 32'(done_cnt), 32'd1);
         check($sformatf("v%0d error", i), 32'(bus.error), 32'd0);
         check($sformatf("v%0d rd left", i), 32'(exp_q.size()), 32'd0);
      end

      // Start timeout: engine never answers
      resp_en = 1'b0;
      en_cnt = 0; done_at = 0; err_at_done = 1'b0;
      send_cmd(1'b0, 10'h020, 11'd1);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.m_enable) en_cnt++;
         if (bus.done && done_at == 0) begin
            done_at = c;
            err_at_done = bus.error;
         end
      end
      check("tmo enable cycles", 32'(en_cnt), 32'd8);
      check("tmo done cycle", 32'(done_at), 32'd10);
      check("tmo error at done", 32'(err_at_done), 32'd1);
      repeat (3) @(negedge clk);
      check("tmo error sticky", 32'(bus.error), 32'd1);
      check("tmo back idle", 32'(bus.cmd_ready), 32'd1);
      resp_en = 1'b1;

      // Zero length: done two cycles after acceptance, clears error
      en_cnt = 0; done_at = 0;
      send_cmd(1'b1, 10'h000, 11'd0);
      check("len0 error cleared", 32'(bus.error), 32'd0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (bus.m_enable) en_cnt++;
         if (bus.done && done_at == 0) done_at = c;
      end
      check("len0 done cycle", 32'(done_at), 32'd2);
      check("len0 no enable", 32'(en_cnt), 32'd0);

      // Reset during RUN of a 16-byte write
      done_cnt = 0; wr_cnt = 0; seg_q.delete();
      send_cmd(1'b0, 10'h040, 11'd16);
      k = 0;
      while (wr_cnt < 3 && k < 200) begin @(negedge clk); k++; end
      check("mid run state", 32'(dbg_state), 32'd3);
      check("mid run cmd_ready", 32'(bus.cmd_ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      wr_at_rst = wr_cnt;
      check("async rst m_enable", 32'(bus.m_enable), 32'd0);
      check("async rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("async rst state", 32'(dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      while (bus.m_busy && k < 200) begin @(negedge clk); k++; end
      check("abort busy drop", 32'(bus.m_busy), 32'd0);
      check("abort no done", 32'(done_cnt), 32'd0);
      check("abort no wr_req", 32'(wr_cnt), 32'(wr_at_rst));

      done_cnt = 0; wr_cnt = 0; rd_cnt = 0; seg_q.delete();
      send_cmd(1'b1, 10'h010, 11'd1);
      wait_done(2000);
      check("post rst nseg", 32'(seg_q.size()), 32'd1);
      if (seg_q.size() > 0) check("post rst seg", seg_q[0], {1'b1, 7'h50, 8'h10, 16'd1});
      check("post rst rd_valid", 32'(rd_cnt), 32'd1);
      check("post rst done", 32'(done_cnt), 32'd1);
      check("post rst error", 32'(bus.error), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
